// File: rtl/exec_ctrl_if.sv
// Handshake and operand bundle between the decode/fetch side, exec_ctrl and the memory stage.
// The slave modport is the execute stage; the master modport drives it.
interface exec_ctrl_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic [W-1:0] valA;
  logic [W-1:0] valB;
  logic [W-1:0] valC;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] valE;
  logic         cnd;
  logic         out_err;

  modport slave (
    input  in_valid, icode, ifun, valA, valB, valC, out_ready,
    output in_ready, out_valid, valE, cnd, out_err
  );

  modport master (
    output in_valid, icode, ifun, valA, valB, valC, out_ready,
    input  in_ready, out_valid, valE, cnd, out_err
  );
endinterface

// File: rtl/exec_ctrl.sv
// Y86-64 SEQ execute stage: selects ALU operands, evaluates Cnd, holds the CC register and
// presents valE/cnd/err through a single-entry registered valid/ready output.
module exec_ctrl #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  exec_ctrl_if.slave   bus,
  output logic [1:0]   o_alu_control,
  output logic [W-1:0] o_alu_a,
  output logic [W-1:0] o_alu_b,
  input  logic [W-1:0] i_alu_result,
  input  logic         i_alu_overflow,
  output logic         o_zf,
  output logic         o_sf,
  output logic         o_of
);

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_NOP    = 4'h1;
  localparam logic [3:0] IC_RRMOVQ = 4'h2;
  localparam logic [3:0] IC_IRMOVQ = 4'h3;
  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_OPQ    = 4'h6;
  localparam logic [3:0] IC_JXX    = 4'h7;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  localparam logic [W-1:0] STACK_DEC = {{(W-4){1'b1}}, 4'b1000};
  localparam logic [W-1:0] STACK_INC = {{(W-4){1'b0}}, 4'b1000};
  localparam logic [W-1:0] ZERO_W    = {W{1'b0}};

  logic         r_out_valid;
  logic [W-1:0] r_valE;
  logic         r_cnd;
  logic         r_err;
  logic         r_zf;
  logic         r_sf;
  logic         r_of;

  logic         w_in_ready;
  logic         w_accept;
  logic         w_invalid;
  logic         w_cnd;
  logic [1:0]   w_ctrl;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;

  // Branch/cmov predicate on the flags held before this instruction's own update.
  function automatic logic f_cond(input logic [3:0] fn, input logic zf, input logic sf,
                                  input logic of_f);
    case (fn)
      4'h0:    return 1'b1;
      4'h1:    return (sf ^ of_f) | zf;
      4'h2:    return sf ^ of_f;
      4'h3:    return zf;
      4'h4:    return ~zf;
      4'h5:    return ~(sf ^ of_f);
      4'h6:    return ~(sf ^ of_f) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

  assign w_in_ready = ~r_out_valid | bus.out_ready;
  assign w_accept   = bus.in_valid & w_in_ready;

  // Instruction validity and condition outcome.
  always_comb begin
    w_invalid = 1'b0;
    w_cnd     = 1'b0;
    if (bus.icode > IC_POPQ) begin
      w_invalid = 1'b1;
    end else if (bus.icode == IC_OPQ) begin
      w_invalid = (bus.ifun > 4'h3);
    end else if ((bus.icode == IC_RRMOVQ) || (bus.icode == IC_JXX)) begin
      w_invalid = (bus.ifun > 4'h6);
      w_cnd     = f_cond(bus.ifun, r_zf, r_sf, r_of);
    end else begin
      w_invalid = 1'b0;
    end
  end

  // ALU operand and function select; invalid encodings feed 0 + 0.
  always_comb begin
    w_ctrl = 2'd0;
    w_a    = ZERO_W;
    w_b    = ZERO_W;
    if (w_invalid) begin
      w_ctrl = 2'd0;
    end else begin
      case (bus.icode)
        IC_OPQ: begin
          w_a    = bus.valB;
          w_b    = bus.valA;
          w_ctrl = bus.ifun[1:0];
        end
        IC_RRMOVQ: w_a = bus.valA;
        IC_IRMOVQ: w_a = bus.valC;
        IC_RMMOVQ, IC_MRMOVQ: begin
          w_a = bus.valB;
          w_b = bus.valC;
        end
        IC_CALL, IC_PUSHQ: begin
          w_a = bus.valB;
          w_b = STACK_DEC;
        end
        IC_RET, IC_POPQ: begin
          w_a = bus.valB;
          w_b = STACK_INC;
        end
        IC_HALT, IC_NOP, IC_JXX: w_ctrl = 2'd0;
        default: w_ctrl = 2'd0;
      endcase
    end
  end

  assign o_alu_control = w_ctrl;
  assign o_alu_a       = w_a;
  assign o_alu_b       = w_b;

  // Output register and condition codes; a stalled output freezes everything.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_valE      <= ZERO_W;
      r_cnd       <= 1'b0;
      r_err       <= 1'b0;
      r_zf        <= 1'b1;
      r_sf        <= 1'b0;
      r_of        <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_valE      <= i_alu_result;
      r_cnd       <= w_cnd;
      r_err       <= w_invalid;
      if ((bus.icode == IC_OPQ) && !w_invalid) begin
        r_zf <= (i_alu_result == ZERO_W);
        r_sf <= i_alu_result[W-1];
        r_of <= i_alu_overflow;
      end
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.valE      = r_valE;
  assign bus.cnd       = r_cnd;
  assign bus.out_err   = r_err;
  assign o_zf          = r_zf;
  assign o_sf          = r_sf;
  assign o_of          = r_of;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl with a behavioural 2-bit ALU attached to its ALU ports.
module tb_exec_ctrl;
  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [1:0]   alu_control;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_overflow;
  logic         zf, sf, of_f;

  int errors = 0;
  int checks = 0;

  exec_ctrl_if #(.W(W)) bus ();

  exec_ctrl #(.W(W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .bus            (bus.slave),
    .o_alu_control  (alu_control),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .i_alu_result   (alu_result),
    .i_alu_overflow (alu_overflow),
    .o_zf           (zf),
    .o_sf           (sf),
    .o_of           (of_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: add/sub with signed overflow, and/xor without.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_control)
      2'd0: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      2'd1: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
      end
      2'd2: alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    bus.in_valid = 1'b1;
    bus.icode    = ic;
    bus.ifun     = fn;
    bus.valA     = a;
    bus.valB     = b;
    bus.valC     = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cc(input string tag, input logic ez, input logic es, input logic eo);
    chk({tag, "_zf"}, W'(zf), W'(ez));
    chk({tag, "_sf"}, W'(sf), W'(es));
    chk({tag, "_of"}, W'(of_f), W'(eo));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.icode     = 4'h1;
    bus.ifun      = 4'h0;
    bus.valA      = '0;
    bus.valB      = '0;
    bus.valC      = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_out_valid", W'(bus.out_valid), 64'd0);
    chk("rst_in_ready", W'(bus.in_ready), 64'd1);
    chk("rst_valE", bus.valE, 64'd0);
    chk_cc("rst", 1'b1, 1'b0, 1'b0);

    // subq 10 - 7
    present(4'h6, 4'h1, 64'd7, 64'd10, 64'd0);
    chk("subq_alu_a", alu_a, 64'd10);
    chk("subq_alu_b", alu_b, 64'd7);
    chk("subq_ctrl", W'(alu_control), 64'd1);
    tick();
    chk("subq_valid", W'(bus.out_valid), 64'd1);
    chk("subq_valE", bus.valE, 64'd3);
    chk("subq_cnd", W'(bus.cnd), 64'd0);
    chk_cc("subq", 1'b0, 1'b0, 1'b0);

    // jg with flags 000 is taken
    present(4'h7, 4'h6, 64'd0, 64'd0, 64'd0);
    chk("jg_alu_a", alu_a, 64'd0);
    tick();
    chk("jg_cnd", W'(bus.cnd), 64'd1);

    // addq overflow
    present(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    tick();
    chk("addq_valE", bus.valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk_cc("addq", 1'b0, 1'b1, 1'b1);

    present(4'h7, 4'h2, 64'd0, 64'd0, 64'd0);
    tick();
    chk("jl_cnd", W'(bus.cnd), 64'd0);
    present(4'h7, 4'h1, 64'd0, 64'd0, 64'd0);
    tick();
    chk("jle_cnd", W'(bus.cnd), 64'd0);
    present(4'h7, 4'h5, 64'd0, 64'd0, 64'd0);
    tick();
    chk("jge_cnd", W'(bus.cnd), 64'd1);

    // subq 4 - 4 then je
    present(4'h6, 4'h1, 64'd4, 64'd4, 64'd0);
    tick();
    chk("sub0_valE", bus.valE, 64'd0);
    chk_cc("sub0", 1'b1, 1'b0, 1'b0);
    present(4'h7, 4'h3, 64'd0, 64'd0, 64'd0);
    tick();
    chk("je_cnd", W'(bus.cnd), 64'd1);

    // stack pointer arithmetic, CC untouched
    present(4'hA, 4'h0, 64'd0, 64'h100, 64'd0);
    chk("push_alu_b", alu_b, 64'hFFFF_FFFF_FFFF_FFF8);
    tick();
    chk("push_valE", bus.valE, 64'hF8);
    chk("push_cnd", W'(bus.cnd), 64'd0);
    chk_cc("push", 1'b1, 1'b0, 1'b0);
    present(4'hB, 4'h0, 64'd0, 64'hF8, 64'd0);
    tick();
    chk("pop_valE", bus.valE, 64'h100);

    present(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234);
    tick();
    chk("irmov_valE", bus.valE, 64'h1234);
    present(4'h4, 4'h0, 64'd0, 64'h10, 64'h20);
    tick();
    chk("rmmov_valE", bus.valE, 64'h30);
    present(4'h2, 4'h0, 64'h55, 64'd0, 64'd0);
    tick();
    chk("rrmov_valE", bus.valE, 64'h55);
    chk("rrmov_cnd", W'(bus.cnd), 64'd1);
    chk("rrmov_err", W'(bus.out_err), 64'd0);

    // idle drains the output
    bus.in_valid = 1'b0;
    tick();
    chk("drain_valid", W'(bus.out_valid), 64'd0);

    // backpressure: addq 6+5 held while out_ready=0
    present(4'h6, 4'h0, 64'd5, 64'd6, 64'd0);
    tick();
    chk("bp_first_valE", bus.valE, 64'd11);
    bus.out_ready = 1'b0;
    present(4'h6, 4'h1, 64'd1, 64'd1, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", W'(bus.in_ready), 64'd0);
      tick();
      chk("bp_valE_held", bus.valE, 64'd11);
      chk("bp_zf_held", W'(zf), 64'd0);
      chk("bp_valid_held", W'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", W'(bus.in_ready), 64'd1);
    tick();
    chk("bp_next_valE", bus.valE, 64'd0);
    chk("bp_next_valid", W'(bus.out_valid), 64'd1);
    chk_cc("bp_next", 1'b1, 1'b0, 1'b0);

    // invalid encodings leave CC alone
    present(4'h6, 4'h0, 64'd1, 64'd2, 64'd0);
    tick();
    chk_cc("pre_inv", 1'b0, 1'b0, 1'b0);
    present(4'h6, 4'h5, 64'd0, 64'd0, 64'd0);
    tick();
    chk("opq_inv_err", W'(bus.out_err), 64'd1);
    chk_cc("opq_inv", 1'b0, 1'b0, 1'b0);
    present(4'h7, 4'h7, 64'd0, 64'd0, 64'd0);
    tick();
    chk("jxx_inv_err", W'(bus.out_err), 64'd1);
    chk("jxx_inv_cnd", W'(bus.cnd), 64'd0);
    present(4'hC, 4'h0, 64'd0, 64'd0, 64'd0);
    tick();
    chk("icode_inv_err", W'(bus.out_err), 64'd1);
    present(4'h0, 4'h0, 64'd0, 64'd0, 64'd0);
    tick();
    chk("halt_err", W'(bus.out_err), 64'd0);

    // reset while a result is pending
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    chk("mid_rst_valid", W'(bus.out_valid), 64'd0);
    chk("mid_rst_err", W'(bus.out_err), 64'd0);
    chk_cc("mid_rst", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
